// File: rtl/logic16_arbiter.sv
// logic16_arbiter: four requesters share one bitwise OR/AND/XOR/NOR unit
// under round-robin arbitration. The result is registered and presented with
// its requester id and opcode on a single valid/ready result port.
module logic16_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [2*N_REQ-1:0]   req_op,
    input  logic [W*N_REQ-1:0]   req_a,
    input  logic [W*N_REQ-1:0]   req_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [W-1:0]         res_data,
    output logic [1:0]           res_id,
    output logic [1:0]           res_op,
    output logic [CNT_W-1:0]     done_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      state;
    logic [1:0]  rr_ptr;
    logic [1:0]  grant;
    logic        any_valid;
    logic        can_accept;
    logic        xfer;
    logic        deliver;
    logic [1:0]  grant_op;
    logic [W-1:0] grant_a;
    logic [W-1:0] grant_b;

    // Bitwise operation selected by the 2-bit opcode.
    function automatic logic [W-1:0] logic_op(input logic [1:0] op,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            2'b00:   r = a | b;
            2'b01:   r = a & b;
            2'b10:   r = a ^ b;
            default: r = ~(a | b);
        endcase
        return r;
    endfunction

    assign any_valid  = |req_valid;
    assign deliver    = res_valid && res_ready;
    // The output register can take a new result when empty or when the held
    // result leaves in this same cycle, giving one result per cycle.
    assign can_accept = (state == EMPTY) || deliver;
    // Nothing is accepted while reset is held.
    assign xfer       = any_valid && can_accept && !rst;

    // Round-robin search: first valid requester at or after rr_ptr, mod 4.
    always_comb begin : arb
        logic       found;
        logic [1:0] idx;
        grant = rr_ptr;
        found = 1'b0;
        idx   = rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            idx = rr_ptr + 2'(k);
            if (!found && req_valid[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    // Only the granted requester sees ready, and only when a transfer happens.
    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[grant] = 1'b1;
        end
    end

    // Operand and opcode steering for the granted requester.
    always_comb begin
        grant_op = req_op[2*int'(grant) +: 2];
        grant_a  = req_a[W*int'(grant) +: W];
        grant_b  = req_b[W*int'(grant) +: W];
    end

    // Output FSM: load on transfer, drain on delivery, hold under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            res_op    <= '0;
            rr_ptr    <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (xfer) begin
                        state     <= FULL;
                        res_valid <= 1'b1;
                        res_data  <= logic_op(grant_op, grant_a, grant_b);
                        res_id    <= grant;
                        res_op    <= grant_op;
                        rr_ptr    <= grant + 2'd1;
                    end
                end
                FULL: begin
                    if (xfer) begin
                        res_valid <= 1'b1;
                        res_data  <= logic_op(grant_op, grant_a, grant_b);
                        res_id    <= grant;
                        res_op    <= grant_op;
                        rr_ptr    <= grant + 2'd1;
                    end else if (deliver) begin
                        state     <= EMPTY;
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

    // Wrapping count of results handed to the consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_cnt <= '0;
        end else if (deliver) begin
            done_cnt <= done_cnt + 1'b1;
        end
    end

endmodule
